// File: rtl/ca_multichannel_router.sv
// ca_multichannel_router
// Distributes host CA words to NUM_SUBCHANNELS per-subchannel FIFOs. Supports
// broadcast, single index, rank decode and mask multicast. A word is accepted
// only when every targeted FIFO has room, so multicast is never partial.
// Optional feature macro: CA_ROUTER_PARITY_EN adds ca_par_in, ca_par_out and
// perr_count. Without it those ports and the parity logic are absent.
module ca_multichannel_router #(
  parameter int CA_WIDTH        = 24,
  parameter int RANK_BITS       = 4,
  parameter int NUM_SUBCHANNELS = 4,
  parameter int FIFO_DEPTH      = 4,
  parameter int SC_BITS         = (NUM_SUBCHANNELS > 1) ? $clog2(NUM_SUBCHANNELS) : 1
) (
  input  logic                                              clk,
  input  logic                                              rst_n,
  input  logic                                              enable,
  input  logic [1:0]                                        routing_mode,
  input  logic [SC_BITS-1:0]                                sc_index,
  input  logic [NUM_SUBCHANNELS-1:0]                        route_mask,
  input  logic                                              flush,
  input  logic [CA_WIDTH-1:0]                               ca_in,
  input  logic [RANK_BITS-1:0]                              ca_rank_in,
  input  logic                                              ca_valid_in,
  output logic                                              ca_ready_out,
  output logic [NUM_SUBCHANNELS*CA_WIDTH-1:0]               ca_out,
  output logic [NUM_SUBCHANNELS*RANK_BITS-1:0]              ca_rank_out,
  output logic [NUM_SUBCHANNELS-1:0]                        ca_valid_out,
  input  logic [NUM_SUBCHANNELS-1:0]                        ca_ready_in,
  output logic [NUM_SUBCHANNELS*($clog2(FIFO_DEPTH)+1)-1:0] fifo_level,
  output logic [31:0]                                       pkt_count,
  output logic [31:0]                                       drop_count,
  output logic [31:0]                                       stall_count,
  output logic                                              overflow_flag,
  input  logic                                              clear_stats
`ifdef CA_ROUTER_PARITY_EN
  ,
  input  logic                                              ca_par_in,
  output logic [NUM_SUBCHANNELS-1:0]                        ca_par_out,
  output logic [31:0]                                       perr_count
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
`ifdef CA_ROUTER_PARITY_EN
  localparam int ENT_W = CA_WIDTH + RANK_BITS + 1;
`else
  localparam int ENT_W = CA_WIDTH + RANK_BITS;
`endif

  typedef enum logic [1:0] {
    MODE_BCAST = 2'b00,
    MODE_INDEX = 2'b01,
    MODE_RANK  = 2'b10,
    MODE_MASK  = 2'b11
  } route_mode_e;

  logic [NUM_SUBCHANNELS-1:0] target;
  logic [NUM_SUBCHANNELS-1:0] full;
  logic                       blocked;
  logic                       accept;
  logic                       stall;
  logic [ENT_W-1:0]           wr_entry;
  int                         rank_sel;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  assign rank_sel = int'(ca_rank_in[SC_BITS-1:0]) % NUM_SUBCHANNELS;

  // Decode the target subchannel set for the current input word.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    target = '0;
    for (int i = 0; i < NUM_SUBCHANNELS; i++) begin
      unique case (route_mode_e'(routing_mode))
        MODE_BCAST: target[i] = 1'b1;
        MODE_INDEX: target[i] = (int'(sc_index) == i);
        MODE_RANK:  target[i] = (rank_sel == i);
        MODE_MASK:  target[i] = route_mask[i];
        default:    target[i] = 1'b0;
      endcase
    end
  end

  // Any targeted FIFO that is full (by registered level) blocks the whole word.
  always_comb begin
    blocked = 1'b0;
    for (int i = 0; i < NUM_SUBCHANNELS; i++) begin
      if (target[i] && full[i]) blocked = 1'b1;
    end
  end

  assign ca_ready_out = enable && !flush && !blocked;
  assign accept       = ca_valid_in && ca_ready_out;
  assign stall        = ca_valid_in && enable && !ca_ready_out;

`ifdef CA_ROUTER_PARITY_EN
  assign wr_entry = {^ca_in, ca_in, ca_rank_in};
`else
  assign wr_entry = {ca_in, ca_rank_in};
`endif

  for (genvar g = 0; g < NUM_SUBCHANNELS; g++) begin : g_sc
    logic [ENT_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [LVL_W-1:0] level;
    logic [ENT_W-1:0] head;
    logic             push;
    logic             pop;

    assign push    = accept && target[g];
    assign pop     = ca_valid_out[g] && ca_ready_in[g] && !flush;
    assign full[g] = (level == LVL_W'(FIFO_DEPTH));
    assign head    = mem[rd_ptr];

    assign ca_valid_out[g]                         = (level != '0);
    assign fifo_level[g*LVL_W +: LVL_W]            = level;
    // Empty FIFOs drive zeros so stale storage never reaches the pins.
    assign ca_out[g*CA_WIDTH +: CA_WIDTH]          = ca_valid_out[g] ? head[RANK_BITS +: CA_WIDTH] : '0;
    assign ca_rank_out[g*RANK_BITS +: RANK_BITS]   = ca_valid_out[g] ? head[RANK_BITS-1:0] : '0;
`ifdef CA_ROUTER_PARITY_EN
    assign ca_par_out[g]                           = ca_valid_out[g] && head[ENT_W-1];
`endif

    // Pointer and level bookkeeping; flush empties the FIFO at the next edge.
    always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (!rst_n) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        level  <= '0;
      end else if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        level  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        case ({push, pop})
          2'b10:   level <= level + 1'b1;
          2'b01:   level <= level - 1'b1;
          default: level <= level;
        endcase
      end
    end

    // Entry storage, written on push.
    always_ff @(posedge clk) begin
      // NOTE: storage has no reset; valid is derived from level, and the outputs are masked while empty.
      if (push) mem[wr_ptr] <= wr_entry;
    end
  end

  // Accepted-word counter: counts words pushed to a non-empty target set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   pkt_count <= '0;
    else if (clear_stats)         pkt_count <= '0;
    else if (accept && |target)   pkt_count <= sat_inc(pkt_count);
  end

  // Drop counter: words consumed with an empty target set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   drop_count <= '0;
    else if (clear_stats)         drop_count <= '0;
    else if (accept && !(|target)) drop_count <= sat_inc(drop_count);
  end

  // Stall counter and sticky overflow indicator.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_count   <= '0;
      overflow_flag <= 1'b0;
    end else if (clear_stats) begin
      stall_count   <= '0;
      overflow_flag <= 1'b0;
    end else if (stall) begin
      stall_count   <= sat_inc(stall_count);
      overflow_flag <= 1'b1;
    end
  end

`ifdef CA_ROUTER_PARITY_EN
  // Parity error counter: accepted words whose ca_par_in disagrees with XOR(ca_in).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                  perr_count <= '0;
    else if (clear_stats)                        perr_count <= '0;
    else if (accept && ((^ca_in) != ca_par_in))  perr_count <= sat_inc(perr_count);
  end
`endif

endmodule
